// File: rtl/minimig_ctrl_initiator.sv
// Host-command bus initiator for the Minimig control block: startup capability read,
// host register reads/writes and periodic audio-overflow polling with clear-on-overflow.
module minimig_ctrl_initiator #(
  parameter int unsigned POLL_PERIOD = 1024,
  parameter logic [6:0]  BASE_ADDR   = 7'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_idx,
  input  logic [15:0] cmd_wdata,
  input  logic [1:0]  cmd_be,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [14:0] addr,
  output logic [15:0] data_out,
  input  logic [15:0] data_in,
  output logic        sel,
  output logic        rd,
  output logic        hwr,
  output logic        lwr,
  input  logic        poll_en,
  output logic [15:0] caps,
  output logic        caps_valid,
  output logic        overflow_seen,
  input  logic        overflow_clr
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 15;
  localparam int unsigned CW = 16;

  localparam logic [CW-1:0] POLL_LAST = CW'(POLL_PERIOD - 1);
  localparam logic [7:0]    IDX_CAPS  = 8'h07;
  localparam logic [7:0]    IDX_AUDIO = 8'h06;

  localparam logic [3:0] INIT_RD   = 4'd0;
  localparam logic [3:0] INIT_WAIT = 4'd1;
  localparam logic [3:0] IDLE      = 4'd2;
  localparam logic [3:0] H_WR      = 4'd3;
  localparam logic [3:0] H_RD      = 4'd4;
  localparam logic [3:0] H_WAIT    = 4'd5;
  localparam logic [3:0] H_RSP     = 4'd6;
  localparam logic [3:0] P_RD      = 4'd7;
  localparam logic [3:0] P_WAIT    = 4'd8;
  localparam logic [3:0] P_CLR     = 4'd9;

  logic [3:0]    state, state_n;
  logic [CW-1:0] poll_cnt, poll_cnt_n;
  logic          poll_pending, poll_pending_n;
  logic          sel_n, rd_n, hwr_n, lwr_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] data_out_n;
  logic          rsp_valid_n;
  logic [DW-1:0] rsp_data_n;
  logic [DW-1:0] caps_n;
  logic          caps_valid_n;
  logic          overflow_seen_n;
  logic          cmd_ready_n;
  logic          poll_wrap;
  logic          overflow_set;

  // Next state plus the bus/response values that will be visible in the next state's cycle.
  always_comb begin
    state_n      = state;
    sel_n        = 1'b0;
    rd_n         = 1'b0;
    hwr_n        = 1'b0;
    lwr_n        = 1'b0;
    addr_n       = '0;
    data_out_n   = '0;
    rsp_valid_n  = 1'b0;
    rsp_data_n   = rsp_data;
    caps_n       = caps;
    caps_valid_n = caps_valid;
    overflow_set = 1'b0;

    unique case (state)
      INIT_RD: begin
        // First cycle after reset has no strobe yet; issue it, then move on once it is out.
        if (rd) begin
          state_n = INIT_WAIT;
        end else begin
          sel_n  = 1'b1;
          rd_n   = 1'b1;
          addr_n = {BASE_ADDR, IDX_CAPS};
        end
      end
      INIT_WAIT: begin
        caps_n       = data_in;
        caps_valid_n = 1'b1;
        state_n      = IDLE;
      end
      IDLE: begin
        if (poll_pending) begin
          state_n = P_RD;
          sel_n   = 1'b1;
          rd_n    = 1'b1;
          addr_n  = {BASE_ADDR, IDX_AUDIO};
        end else if (cmd_valid && cmd_ready) begin
          sel_n  = 1'b1;
          addr_n = {BASE_ADDR, cmd_idx};
          if (cmd_write) begin
            state_n    = H_WR;
            hwr_n      = cmd_be[1];
            lwr_n      = cmd_be[0];
            data_out_n = cmd_wdata;
          end else begin
            state_n = H_RD;
            rd_n    = 1'b1;
          end
        end
      end
      H_WR: begin
        state_n     = H_RSP;
        rsp_valid_n = 1'b1;
        rsp_data_n  = '0;
      end
      H_RD:   state_n = H_WAIT;
      H_WAIT: begin
        state_n     = H_RSP;
        rsp_valid_n = 1'b1;
        rsp_data_n  = data_in;
      end
      H_RSP:  state_n = IDLE;
      P_RD:   state_n = P_WAIT;
      P_WAIT: begin
        if (data_in[0]) begin
          overflow_set = 1'b1;
          state_n      = P_CLR;
          sel_n        = 1'b1;
          lwr_n        = 1'b1;
          addr_n       = {BASE_ADDR, IDX_AUDIO};
        end else begin
          state_n = IDLE;
        end
      end
      P_CLR:   state_n = IDLE;
      default: state_n = INIT_RD;
    endcase

    // Poll timer; at most one poll outstanding, so a wrap while pending changes nothing.
    poll_wrap  = poll_en && (poll_cnt == POLL_LAST);
    poll_cnt_n = (!poll_en || poll_wrap) ? '0 : poll_cnt + CW'(1);
    if (!poll_en) begin
      poll_pending_n = 1'b0;
    end else if (poll_wrap) begin
      poll_pending_n = 1'b1;
    end else if (state == IDLE && poll_pending) begin
      poll_pending_n = 1'b0;
    end else begin
      poll_pending_n = poll_pending;
    end

    if (overflow_set) begin
      overflow_seen_n = 1'b1;
    end else if (overflow_clr) begin
      overflow_seen_n = 1'b0;
    end else begin
      overflow_seen_n = overflow_seen;
    end

    cmd_ready_n = (state_n == IDLE) && !poll_pending_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT_RD;
      poll_cnt      <= '0;
      poll_pending  <= 1'b0;
      sel           <= 1'b0;
      rd            <= 1'b0;
      hwr           <= 1'b0;
      lwr           <= 1'b0;
      addr          <= '0;
      data_out      <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      caps          <= '0;
      caps_valid    <= 1'b0;
      overflow_seen <= 1'b0;
      cmd_ready     <= 1'b0;
    end else begin
      state         <= state_n;
      poll_cnt      <= poll_cnt_n;
      poll_pending  <= poll_pending_n;
      sel           <= sel_n;
      rd            <= rd_n;
      hwr           <= hwr_n;
      lwr           <= lwr_n;
      addr          <= addr_n;
      data_out      <= data_out_n;
      rsp_valid     <= rsp_valid_n;
      rsp_data      <= rsp_data_n;
      caps          <= caps_n;
      caps_valid    <= caps_valid_n;
      overflow_seen <= overflow_seen_n;
      cmd_ready     <= cmd_ready_n;
    end
  end

endmodule
